step_sequencer: RTL

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer_if.sv | 34 +++
 rtl/step_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/step_sequencer_if.sv
// Control, status and pattern-store write bus of the step sequencer.
// The slave modport is the sequencer's view; the master modport is the driver's view.
interface step_sequencer_if #(
  parameter int PATTERN_WIDTH    = 8,
  parameter int COUNT_WIDTH      = 4,
  parameter int DRUM_COUNT_WIDTH = 3,
  parameter int TEMPO_WIDTH      = 16
);
  logic                        start_i;
  logic                        stop_i;
  logic [TEMPO_WIDTH-1:0]      tempo_i;
  logic [COUNT_WIDTH-1:0]      len_i;
  logic                        wr_valid_i;
  logic [DRUM_COUNT_WIDTH-1:0] wr_drum_i;
  logic [PATTERN_WIDTH-1:0]    wr_pattern_i;
  logic                        wr_ready_o;
  logic [DRUM_COUNT_WIDTH-1:0] sel_o;
  logic [PATTERN_WIDTH-1:0]    pattern_o;
  logic                        en_o_n;
  logic [COUNT_WIDTH-1:0]      step_o;
  logic                        step_stb_o;
  logic                        loop_o;
  logic                        running_o;

  modport slave (
    input  start_i, stop_i, tempo_i, len_i, wr_valid_i, wr_drum_i, wr_pattern_i,
    output wr_ready_o, sel_o, pattern_o, en_o_n, step_o, step_stb_o, loop_o, running_o
  );

  modport master (
    output start_i, stop_i, tempo_i, len_i, wr_valid_i, wr_drum_i, wr_pattern_i,
    input  wr_ready_o, sel_o, pattern_o, en_o_n, step_o, step_stb_o, loop_o, running_o
  );
endinterface

// File: rtl/step_sequencer.sv
// Drum-machine step sequencer: tempo-driven step counter with looping, plus an
// independent one-cycle write port into an external pattern store.
module step_sequencer #(
  parameter int PATTERN_WIDTH    = 8,
  parameter int COUNT_WIDTH      = 4,
  parameter int DRUM_COUNT       = 5,
  parameter int DRUM_COUNT_WIDTH = 3,
  parameter int TEMPO_WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  step_sequencer_if.slave  bus
);
  typedef enum logic {IDLE, RUN}    play_state_t;
  typedef enum logic {WIDLE, WRITE} wr_state_t;

  play_state_t              state_reg, state_next;
  logic [COUNT_WIDTH-1:0]   step_reg, step_next;
  logic [COUNT_WIDTH-1:0]   len_reg, len_next;
  logic [TEMPO_WIDTH-1:0]   tick_reg, tick_next;
  logic [TEMPO_WIDTH-1:0]   tempo_reg, tempo_next;
  logic                     stb_reg, stb_next;
  logic                     loop_reg, loop_next;
  logic [COUNT_WIDTH-1:0]   eff_len;
  logic                     last_step;

  wr_state_t                   wstate_reg, wstate_next;
  logic [DRUM_COUNT_WIDTH-1:0] sel_reg, sel_next;
  logic [PATTERN_WIDTH-1:0]    pattern_reg, pattern_next;
  logic                        en_n_reg, en_n_next;
  logic                        accept;
  logic                        drum_ok;

  // Out-of-range loop lengths (0 or beyond the row) play the whole row.
  always_comb begin
    eff_len = bus.len_i;
    if (bus.len_i == '0 || 32'(bus.len_i) > PATTERN_WIDTH)
      eff_len = COUNT_WIDTH'(PATTERN_WIDTH);
  end

  // ">=" rather than "==" so a loop shortened below the current step wraps promptly.
  assign last_step = ({1'b0, step_reg} + (COUNT_WIDTH+1)'(1)) >= {1'b0, len_reg};

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    tick_next  = tick_reg;
    tempo_next = tempo_reg;
    len_next   = len_reg;
    stb_next   = 1'b0;
    loop_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          state_next = RUN;
          step_next  = '0;
          tick_next  = '0;
          tempo_next = bus.tempo_i;
          len_next   = eff_len;
          stb_next   = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop_i) begin
          state_next = IDLE;
          step_next  = '0;
          tick_next  = '0;
        end else if (tick_reg == tempo_reg) begin
          tick_next  = '0;
          stb_next   = 1'b1;
          tempo_next = bus.tempo_i;
          len_next   = eff_len;
          if (last_step) begin
            step_next = '0;
            loop_next = 1'b1;
          end else begin
            step_next = step_reg + COUNT_WIDTH'(1);
          end
        end else begin
          tick_next = tick_reg + TEMPO_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      tick_reg  <= '0;
      tempo_reg <= '0;
      len_reg   <= COUNT_WIDTH'(PATTERN_WIDTH);
      stb_reg   <= 1'b0;
      loop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      tick_reg  <= tick_next;
      tempo_reg <= tempo_next;
      len_reg   <= len_next;
      stb_reg   <= stb_next;
      loop_reg  <= loop_next;
    end
  end

  // Requests to nonexistent drums still take the handshake slot but never strobe the store.
  always_comb begin
    accept       = bus.wr_valid_i && (wstate_reg == WIDLE);
    drum_ok      = 32'(bus.wr_drum_i) < DRUM_COUNT;
    wstate_next  = wstate_reg;
    sel_next     = sel_reg;
    pattern_next = pattern_reg;
    en_n_next    = 1'b1;
    case (wstate_reg)
      WIDLE: begin
        if (accept) begin
          wstate_next = WRITE;
          if (drum_ok) begin
            sel_next     = bus.wr_drum_i;
            pattern_next = bus.wr_pattern_i;
            en_n_next    = 1'b0;
          end
        end
      end
      WRITE:   wstate_next = WIDLE;
      default: wstate_next = WIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_reg  <= WIDLE;
      sel_reg     <= '0;
      pattern_reg <= '0;
      en_n_reg    <= 1'b1;
    end else begin
      wstate_reg  <= wstate_next;
      sel_reg     <= sel_next;
      pattern_reg <= pattern_next;
      en_n_reg    <= en_n_next;
    end
  end

  assign bus.step_o     = step_reg;
  assign bus.step_stb_o = stb_reg;
  assign bus.loop_o     = loop_reg;
  assign bus.running_o  = (state_reg == RUN);
  assign bus.wr_ready_o = (wstate_reg == WIDLE);
  assign bus.sel_o      = sel_reg;
  assign bus.pattern_o  = pattern_reg;
  assign bus.en_o_n     = en_n_reg;
endmodule
